stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter SP_INIT, default 8'hFF: stack pointer value at reset, which is the empty stack.
REQ-002 Parameter SP_LIMIT, default 8'h80: lowest address the stack may write.
REQ-003 Clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Rst, input, 1: reset, asynchronous, active-low.
REQ-005 Push / Pop / Call / Ret / Intr / Rti, input, 1 each: stack requests from decode, sampled only in IDLE.
REQ-006 Push_Data, input, 8: register value to push.
REQ-007 Pc_Next, input, 8: return address for Call and Intr.
REQ-008 Flags, input, 4: flags to save on Intr.
REQ-009 X, input, 8: stack read data from data memory, which returns mem[Sp] combinationally.
REQ-010 Clr_Err, input, 1: clears the sticky error flags.
REQ-011 Sp, output, 8: stack address to data memory (combinational).
REQ-012 W_Sp, output, 1: stack write strobe to data memory (combinational).
REQ-013 WD, output, 8: stack write data (combinational).
REQ-014 Pop_Data, output, 8, with Pop_Valid, output, 1: popped byte and its valid strobe (registered).
REQ-015 Pc_Value, output, 8, with Pc_Load, output, 1: PC restore value and load strobe (registered).
REQ-016 Flags_Value, output, 4, with Flags_Load, output, 1: flags restore value and load strobe (registered).
REQ-017 Busy, output, 1: pipeline stall request; high whenever the FSM is not IDLE.
REQ-018 Ovf / Unf, output, 1 each: sticky overflow and underflow flags.

Function
REQ-019 Internal register SPR is the full-descending "next free slot" pointer; a push writes mem[SPR] and then sets SPR-1; a pop reads mem[SPR+1] and then sets SPR+1.
REQ-020 FSM states: IDLE, INT_PUSH2, RTI_POP2; INT_PUSH2 and RTI_POP2 always return to IDLE after one cycle.
REQ-021 Request priority in IDLE: Intr > Rti > Ret > Call > Pop > Push; lower-priority requests in the same cycle are dropped.
REQ-022 Sp output: SPR+1 in IDLE when the winning request is Pop, Ret or Rti, and in RTI_POP2; SPR in all other cases.
REQ-023 Push when SPR >= SP_LIMIT: W_Sp=1, WD=Push_Data, SPR decrements.
REQ-024 Call when SPR >= SP_LIMIT: W_Sp=1, WD=Pc_Next, SPR decrements.
REQ-025 Pop when SPR < SP_INIT: SPR increments; next cycle Pop_Valid=1 and Pop_Data=X captured.
REQ-026 Ret when SPR < SP_INIT: SPR increments; next cycle Pc_Load=1 and Pc_Value=X captured.
REQ-027 Intr when SPR >= SP_LIMIT+1:
  - cycle 1: W_Sp=1, WD=Pc_Next, SPR decrements, go to INT_PUSH2;
  - cycle 2: W_Sp=1, WD={4'b0,Flags}, SPR decrements, go to IDLE.
REQ-028 Flags used in INT_PUSH2 are the value captured in cycle 1.
REQ-029 Rti when SPR <= SP_INIT-2:
  - cycle 1: read flags, SPR increments, go to RTI_POP2; next cycle Flags_Load=1, Flags_Value=X[3:0];
  - cycle 2: read PC, SPR increments, go to IDLE; next cycle Pc_Load=1, Pc_Value=X.
REQ-030 Overflow: Push, Call or Intr that fails its space check sets Ovf, performs no write (W_Sp=0), leaves SPR unchanged and stays in IDLE.
REQ-031 Underflow: Pop, Ret or Rti that fails its depth check sets Unf, issues no strobes, leaves SPR unchanged and stays in IDLE.
REQ-032 Pop_Valid, Pc_Load and Flags_Load are single-cycle pulses; their data outputs hold their last value otherwise.
REQ-033 Clr_Err clears Ovf and Unf; if Clr_Err coincides with a new error, the error wins.
REQ-034 Requests arriving while Busy=1 are ignored.
REQ-035 SPR arithmetic is 8-bit; the space and depth checks guarantee SPR never wraps.

Reset
REQ-036 Rst=0 asynchronously sets:
  - SPR=SP_INIT, FSM=IDLE;
  - Pop_Data=0, Pop_Valid=0, Pc_Value=0, Pc_Load=0, Flags_Value=0, Flags_Load=0;
  - Ovf=0, Unf=0, Busy=0.
REQ-037 Rst asserted mid-Intr or mid-Rti aborts the sequence; no further writes or loads occur.
REQ-038 W_Sp=0 while Rst=0.

Verification
REQ-039 Push 8'hA5 then Pop -> write at Sp=FF; read at Sp=FF next cycle; Pop_Data=A5 with Pop_Valid one cycle later; SPR back to FF.
REQ-040 Intr with Pc_Next=8'h3C, Flags=4'h9 -> mem[FF]=3C, mem[FE]=09, Busy high for 1 cycle; then Rti -> Flags_Value=9, then Pc_Value=3C, Pc_Load one cycle after Flags_Load; SPR=FF.
REQ-041 Pop at reset -> Unf=1, no Pop_Valid, SPR=FF; Clr_Err -> Unf=0.
REQ-042 Push 128 times from reset -> last write at Sp=80, SPR=7F; 129th Push -> Ovf=1, W_Sp=0; Intr at SPR=80 -> Ovf=1, no writes.
REQ-043 Push+Pop+Call in the same cycle -> only Call executes; Rst pulled low during INT_PUSH2 -> no second write, SPR=FF.

Source files
------------

// File: rtl/stack_unit.sv
// stack_unit: full-descending hardware stack controller.
// Handles register push/pop, call/return and the two-byte interrupt
// entry/exit sequences against an external data memory whose read
// port returns mem[Sp] combinationally.
//
// Handshake: requests are single-cycle level inputs sampled only while
// Busy=0. Outputs Pop_Valid, Pc_Load and Flags_Load are one-cycle
// valid pulses; their data outputs are valid in that same cycle and
// have no ready back-pressure.
module stack_unit #(
  parameter logic [7:0] SP_INIT  = 8'hFF,
  parameter logic [7:0] SP_LIMIT = 8'h80
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Push,
  input  logic       Pop,
  input  logic       Call,
  input  logic       Ret,
  input  logic       Intr,
  input  logic       Rti,
  input  logic [7:0] Push_Data,
  input  logic [7:0] Pc_Next,
  input  logic [3:0] Flags,
  input  logic [7:0] X,
  input  logic       Clr_Err,
  output logic [7:0] Sp,
  output logic       W_Sp,
  output logic [7:0] WD,
  output logic [7:0] Pop_Data,
  output logic       Pop_Valid,
  output logic [7:0] Pc_Value,
  output logic       Pc_Load,
  output logic [3:0] Flags_Value,
  output logic       Flags_Load,
  output logic       Busy,
  output logic       Ovf,
  output logic       Unf,
  output logic [1:0] state_dbg,
  output logic [7:0] spr_dbg
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_INT_PUSH2 = 2'd1,
    S_RTI_POP2  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    R_NONE, R_PUSH, R_POP, R_CALL, R_RET, R_INTR, R_RTI
  } req_t;

  // Intr needs two free slots; Rti needs two occupied slots.
  localparam logic [7:0] INTR_MIN = SP_LIMIT + 8'd1;
  localparam logic [7:0] RTI_MAX  = SP_INIT - 8'd2;

  state_t     state;
  req_t       req;
  logic [7:0] spr;
  logic [3:0] flags_q;
  logic       has_space;
  logic       has_space2;
  logic       has_depth;
  logic       has_depth2;
  logic       w_sp_int;
  logic       ovf_set;
  logic       unf_set;

  assign has_space  = (spr >= SP_LIMIT);
  assign has_space2 = (spr >= INTR_MIN);
  assign has_depth  = (spr < SP_INIT);
  assign has_depth2 = (spr <= RTI_MAX);

  assign Busy      = (state != S_IDLE);
  assign state_dbg = state;
  assign spr_dbg   = spr;
  // Write strobe is forced low while reset is held.
  assign W_Sp      = w_sp_int & Rst;

  // Fixed-priority selection of the winning request.
  always_comb begin
    req = R_NONE;
    if (Intr)      req = R_INTR;
    else if (Rti)  req = R_RTI;
    else if (Ret)  req = R_RET;
    else if (Call) req = R_CALL;
    else if (Pop)  req = R_POP;
    else if (Push) req = R_PUSH;
  end

  // Memory address/write port and error detection for the current cycle.
  always_comb begin
    Sp       = spr;
    w_sp_int = 1'b0;
    WD       = 8'h00;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    case (state)
      S_IDLE: begin
        case (req)
          R_PUSH: begin
            if (has_space) begin
              w_sp_int = 1'b1;
              WD       = Push_Data;
            end else begin
              ovf_set = 1'b1;
            end
          end
          R_CALL: begin
            if (has_space) begin
              w_sp_int = 1'b1;
              WD       = Pc_Next;
            end else begin
              ovf_set = 1'b1;
            end
          end
          R_INTR: begin
            if (has_space2) begin
              w_sp_int = 1'b1;
              WD       = Pc_Next;
            end else begin
              ovf_set = 1'b1;
            end
          end
          R_POP, R_RET: begin
            Sp = spr + 8'd1;
            if (!has_depth) unf_set = 1'b1;
          end
          R_RTI: begin
            Sp = spr + 8'd1;
            if (!has_depth2) unf_set = 1'b1;
          end
          default: ;
        endcase
      end
      S_INT_PUSH2: begin
        w_sp_int = 1'b1;
        WD       = {4'b0000, flags_q};
      end
      S_RTI_POP2: begin
        Sp = spr + 8'd1;
      end
      default: ;
    endcase
  end

  // Stack pointer, sequence FSM, registered result strobes and sticky errors.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= S_IDLE;
      spr         <= SP_INIT;
      flags_q     <= 4'h0;
      Pop_Data    <= 8'h00;
      Pop_Valid   <= 1'b0;
      Pc_Value    <= 8'h00;
      Pc_Load     <= 1'b0;
      Flags_Value <= 4'h0;
      Flags_Load  <= 1'b0;
      Ovf         <= 1'b0;
      Unf         <= 1'b0;
    end else begin
      Pop_Valid  <= 1'b0;
      Pc_Load    <= 1'b0;
      Flags_Load <= 1'b0;

      // A new error takes precedence over a simultaneous clear.
      if (ovf_set)      Ovf <= 1'b1;
      else if (Clr_Err) Ovf <= 1'b0;
      if (unf_set)      Unf <= 1'b1;
      else if (Clr_Err) Unf <= 1'b0;

      case (state)
        S_IDLE: begin
          case (req)
            R_PUSH, R_CALL: begin
              if (has_space) spr <= spr - 8'd1;
            end
            R_INTR: begin
              if (has_space2) begin
                spr     <= spr - 8'd1;
                flags_q <= Flags;
                state   <= S_INT_PUSH2;
              end
            end
            R_POP: begin
              if (has_depth) begin
                spr       <= spr + 8'd1;
                Pop_Data  <= X;
                Pop_Valid <= 1'b1;
              end
            end
            R_RET: begin
              if (has_depth) begin
                spr      <= spr + 8'd1;
                Pc_Value <= X;
                Pc_Load  <= 1'b1;
              end
            end
            R_RTI: begin
              if (has_depth2) begin
                spr         <= spr + 8'd1;
                Flags_Value <= X[3:0];
                Flags_Load  <= 1'b1;
                state       <= S_RTI_POP2;
              end
            end
            default: ;
          endcase
        end
        S_INT_PUSH2: begin
          spr   <= spr - 8'd1;
          state <= S_IDLE;
        end
        S_RTI_POP2: begin
          spr      <= spr + 8'd1;
          Pc_Value <= X;
          Pc_Load  <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed bench for stack_unit with a behavioural data
// memory, expected-value queues filled by the drivers and a negedge
// monitor that pops and compares whenever the DUT strobes an output.
module tb_stack_unit;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Push = 1'b0, Pop = 1'b0, Call = 1'b0, Ret = 1'b0;
  logic       Intr = 1'b0, Rti = 1'b0, Clr_Err = 1'b0;
  logic [7:0] Push_Data = 8'h00;
  logic [7:0] Pc_Next = 8'h00;
  logic [3:0] Flags = 4'h0;
  logic [7:0] X;
  logic [7:0] Sp, WD, Pop_Data, Pc_Value, spr_dbg;
  logic       W_Sp, Pop_Valid, Pc_Load, Flags_Load, Busy, Ovf, Unf;
  logic [3:0] Flags_Value;
  logic [1:0] state_dbg;

  logic [7:0]  mem [256];
  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_pop_q[$];
  logic [7:0]  exp_pc_q[$];
  logic [7:0]  exp_flags_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int flags_cyc = 0;
  int pc_cyc = 0;

  stack_unit dut (
    .Clk(Clk), .Rst(Rst), .Push(Push), .Pop(Pop), .Call(Call), .Ret(Ret),
    .Intr(Intr), .Rti(Rti), .Push_Data(Push_Data), .Pc_Next(Pc_Next),
    .Flags(Flags), .X(X), .Clr_Err(Clr_Err), .Sp(Sp), .W_Sp(W_Sp), .WD(WD),
    .Pop_Data(Pop_Data), .Pop_Valid(Pop_Valid), .Pc_Value(Pc_Value),
    .Pc_Load(Pc_Load), .Flags_Value(Flags_Value), .Flags_Load(Flags_Load),
    .Busy(Busy), .Ovf(Ovf), .Unf(Unf), .state_dbg(state_dbg), .spr_dbg(spr_dbg)
  );

  // Clock and cycle counter.
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural data memory: combinational read, clocked write.
  assign X = mem[Sp];
  always @(posedge Clk) if (W_Sp) mem[Sp] <= WD;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: every output strobe must match the head of its expected queue.
  always @(negedge Clk) begin
    if (W_Sp) begin
      if (exp_wr_q.size() == 0) chk("unexpected_write", {Sp, WD}, 16'hxxxx);
      else chk("write_addr_data", {Sp, WD}, exp_wr_q.pop_front());
    end
    if (Pop_Valid) begin
      if (exp_pop_q.size() == 0) chk("unexpected_pop_valid", {8'h00, Pop_Data}, 16'hxxxx);
      else chk("pop_data", {8'h00, Pop_Data}, {8'h00, exp_pop_q.pop_front()});
    end
    if (Pc_Load) begin
      pc_cyc = cyc;
      if (exp_pc_q.size() == 0) chk("unexpected_pc_load", {8'h00, Pc_Value}, 16'hxxxx);
      else chk("pc_value", {8'h00, Pc_Value}, {8'h00, exp_pc_q.pop_front()});
    end
    if (Flags_Load) begin
      flags_cyc = cyc;
      if (exp_flags_q.size() == 0) chk("unexpected_flags_load", {12'h000, Flags_Value}, 16'hxxxx);
      else chk("flags_value", {12'h000, Flags_Value}, {8'h00, exp_flags_q.pop_front()});
    end
  end

  task automatic do_reset();
    Rst = 1'b0;
    #1;
    chk("rst_w_sp", {15'd0, W_Sp}, 16'd0);
    repeat (2) tick();
    chk("rst_spr", {8'h00, spr_dbg}, 16'h00FF);
    chk("rst_busy", {15'd0, Busy}, 16'd0);
    chk("rst_errs", {14'd0, Ovf, Unf}, 16'd0);
    Rst = 1'b1;
  endtask

  task automatic clr_err();
    Clr_Err = 1'b1;
    tick();
    Clr_Err = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #2;

    // Reset values of the registered outputs.
    Rst = 1'b0;
    #1;
    chk("rst_outputs", {Pop_Data, Pop_Valid, Pc_Load, Flags_Load, 5'd0}, 16'h0000);
    chk("rst_values", {Pc_Value, Flags_Value, 4'h0}, 16'h0000);
    do_reset();
    tick();

    // Push A5 then Pop.
    Push = 1'b1; Push_Data = 8'hA5;
    exp_wr_q.push_back({8'hFF, 8'hA5});
    tick();
    Push = 1'b0; Pop = 1'b1;
    #1;
    chk("pop_read_addr", {8'h00, Sp}, 16'h00FF);
    exp_pop_q.push_back(8'hA5);
    tick();
    Pop = 1'b0;
    tick();
    chk("push_pop_spr", {8'h00, spr_dbg}, 16'h00FF);

    // Interrupt entry then return from interrupt.
    Intr = 1'b1; Pc_Next = 8'h3C; Flags = 4'h9;
    exp_wr_q.push_back({8'hFF, 8'h3C});
    exp_wr_q.push_back({8'hFE, 8'h09});
    tick();
    Intr = 1'b0; Flags = 4'h0; Pc_Next = 8'h00;
    chk("intr_busy", {15'd0, Busy}, 16'd1);
    tick();
    chk("intr_busy_done", {15'd0, Busy}, 16'd0);
    chk("intr_spr", {8'h00, spr_dbg}, 16'h00FD);
    Rti = 1'b1;
    exp_flags_q.push_back(8'h09);
    exp_pc_q.push_back(8'h3C);
    tick();
    Rti = 1'b0;
    chk("rti_busy", {15'd0, Busy}, 16'd1);
    repeat (2) tick();
    chk("rti_spr", {8'h00, spr_dbg}, 16'h00FF);
    chk("rti_load_order", pc_cyc - flags_cyc, 16'd1);

    // Pop on empty stack: underflow, then clear; error beats clear.
    Pop = 1'b1;
    tick();
    Pop = 1'b0;
    chk("unf_set", {15'd0, Unf}, 16'd1);
    chk("unf_spr", {8'h00, spr_dbg}, 16'h00FF);
    clr_err();
    chk("unf_clear", {15'd0, Unf}, 16'd0);
    Pop = 1'b1; Clr_Err = 1'b1;
    tick();
    Pop = 1'b0; Clr_Err = 1'b0;
    chk("unf_wins_clear", {15'd0, Unf}, 16'd1);
    clr_err();

    // Push+Pop+Call together: only Call runs; then Ret.
    Push = 1'b1; Pop = 1'b1; Call = 1'b1; Push_Data = 8'h11; Pc_Next = 8'h5A;
    exp_wr_q.push_back({8'hFF, 8'h5A});
    tick();
    Push = 1'b0; Pop = 1'b0; Call = 1'b0;
    chk("call_spr", {8'h00, spr_dbg}, 16'h00FE);
    Ret = 1'b1;
    exp_pc_q.push_back(8'h5A);
    tick();
    Ret = 1'b0;
    tick();
    chk("ret_spr", {8'h00, spr_dbg}, 16'h00FF);

    // Rti with only one byte on the stack underflows.
    Push = 1'b1; Push_Data = 8'h77;
    exp_wr_q.push_back({8'hFF, 8'h77});
    tick();
    Push = 1'b0; Rti = 1'b1;
    tick();
    Rti = 1'b0;
    chk("rti_unf", {15'd0, Unf}, 16'd1);
    chk("rti_unf_spr", {8'h00, spr_dbg}, 16'h00FE);
    chk("rti_unf_busy", {15'd0, Busy}, 16'd0);
    clr_err();
    Pop = 1'b1;
    exp_pop_q.push_back(8'h77);
    tick();
    Pop = 1'b0;
    tick();

    // Fill the stack to SP_LIMIT, then overflow with Push and with Intr.
    for (int i = 0; i < 128; i++) begin
      Push = 1'b1; Push_Data = 8'(i);
      exp_wr_q.push_back({8'(8'hFF - i), 8'(i)});
      tick();
    end
    Push = 1'b0;
    chk("full_spr", {8'h00, spr_dbg}, 16'h007F);
    Push = 1'b1; Push_Data = 8'hEE;
    #1;
    chk("ovf_no_write", {15'd0, W_Sp}, 16'd0);
    tick();
    Push = 1'b0;
    chk("ovf_set", {15'd0, Ovf}, 16'd1);
    chk("ovf_spr", {8'h00, spr_dbg}, 16'h007F);
    clr_err();
    chk("ovf_clear", {15'd0, Ovf}, 16'd0);
    Pop = 1'b1;
    exp_pop_q.push_back(8'h7F);
    tick();
    Pop = 1'b0;
    chk("one_free_spr", {8'h00, spr_dbg}, 16'h0080);
    Intr = 1'b1; Pc_Next = 8'h44; Flags = 4'h2;
    #1;
    chk("intr_ovf_no_write", {15'd0, W_Sp}, 16'd0);
    tick();
    Intr = 1'b0;
    chk("intr_ovf", {15'd0, Ovf}, 16'd1);
    chk("intr_ovf_busy", {15'd0, Busy}, 16'd0);
    chk("intr_ovf_spr", {8'h00, spr_dbg}, 16'h0080);
    clr_err();

    // Requests while Busy are ignored.
    do_reset();
    tick();
    Intr = 1'b1; Pc_Next = 8'h21; Flags = 4'h5;
    exp_wr_q.push_back({8'hFF, 8'h21});
    exp_wr_q.push_back({8'hFE, 8'h05});
    tick();
    Intr = 1'b0; Push = 1'b1; Pop = 1'b1; Push_Data = 8'h99;
    tick();
    Push = 1'b0; Pop = 1'b0;
    chk("busy_ignore_spr", {8'h00, spr_dbg}, 16'h00FD);

    // Reset during the second interrupt cycle aborts the sequence.
    do_reset();
    tick();
    Intr = 1'b1; Pc_Next = 8'h11; Flags = 4'h3;
    exp_wr_q.push_back({8'hFF, 8'h11});
    tick();
    Intr = 1'b0;
    Rst = 1'b0;
    #1;
    chk("abort_no_write", {15'd0, W_Sp}, 16'd0);
    chk("abort_spr", {8'h00, spr_dbg}, 16'h00FF);
    repeat (2) tick();
    Rst = 1'b1;
    repeat (3) tick();
    chk("abort_spr_after", {8'h00, spr_dbg}, 16'h00FF);

    // All expected responses must have been consumed.
    chk("wr_q_empty", 16'(exp_wr_q.size()), 16'd0);
    chk("pop_q_empty", 16'(exp_pop_q.size()), 16'd0);
    chk("pc_q_empty", 16'(exp_pc_q.size()), 16'd0);
    chk("flags_q_empty", 16'(exp_flags_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
